// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 16-bit SRAM bus between the instruction-fetch
// port and the data port. Each granted access runs a registered strobe
// sequence on the SRAM pins and finishes with a one-cycle ack carrying the
// read data. Stall requests follow the ports' pending state combinationally.
//
// Optional build macro MEM_ARB_FETCH_BUF_EN adds a one-entry fetch buffer
// that answers a repeated fetch from the last fetched address without an
// SRAM cycle. Any completed store invalidates it.
module mem_bus_arbiter #(
  parameter int WAIT_CYCLES = 1,   // strobe length in cycles, 1..7
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [15:0]       if_rdata,
  output logic              if_ack,
  // data port
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic              mem_ack,
  // pipeline stall requests
  output logic              stall_req_if,
  output logic              stall_req_mem,
  // SRAM pins
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic              ram_data_oe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_STB,
    S_WR_SETUP,
    S_WR_STB,
    S_ACK
  } state_t;

  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;
  // strobe counter runs 0..WAIT_CYCLES-1 inside a strobe state
  localparam logic [2:0] LAST_STB = 3'(WAIT_CYCLES - 1);

  state_t              r_state, w_state_next;
  logic                r_last_grant, w_last_grant_next;
  logic [2:0]          r_cnt, w_cnt_next;
  logic                r_if_ack, w_if_ack_next;
  logic                r_mem_ack, w_mem_ack_next;
  logic [15:0]         r_if_rdata, w_if_rdata_next;
  logic [15:0]         r_mem_rdata, w_mem_rdata_next;
  logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_next;
  logic [15:0]         r_ram_wdata, w_ram_wdata_next;
  logic                r_data_oe, w_data_oe_next;
  logic                r_ce_n, w_ce_n_next;
  logic                r_oe_n, w_oe_n_next;
  logic                r_we_n, w_we_n_next;

  logic                w_stb_last;
  logic                w_rd_done;
  logic                w_wr_done;
  logic                w_pick_mem;
  logic                w_fb_hit;
  logic [15:0]         w_fb_data;

  // A request is pending until its ack cycle
  assign stall_req_if  = if_req  & ~r_if_ack;
  assign stall_req_mem = mem_req & ~r_mem_ack;

  assign if_ack      = r_if_ack;
  assign mem_ack     = r_mem_ack;
  assign if_rdata    = r_if_rdata;
  assign mem_rdata   = r_mem_rdata;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign ram_data_oe = r_data_oe;
  assign ram_ce_n    = r_ce_n;
  assign ram_oe_n    = r_oe_n;
  assign ram_we_n    = r_we_n;

  assign w_stb_last = (r_cnt == LAST_STB);
  assign w_rd_done  = (r_state == S_RD_STB) && w_stb_last;
  assign w_wr_done  = (r_state == S_WR_STB) && w_stb_last;
  // MEM wins a tie unless it had the previous grant
  assign w_pick_mem = mem_req & (~if_req | (r_last_grant == GRANT_IF));

`ifdef MEM_ARB_FETCH_BUF_EN
  logic              r_fb_valid, w_fb_valid_next;
  logic [ADDR_W-1:0] r_fb_tag, w_fb_tag_next;
  logic [15:0]       r_fb_data, w_fb_data_next;

  // Only a lone fetch may be answered from the buffer
  assign w_fb_hit  = if_req & ~mem_req & r_fb_valid & (r_fb_tag == if_addr);
  assign w_fb_data = r_fb_data;

  // Refill on every finished SRAM fetch, drop on every finished store
  always_comb begin
    w_fb_valid_next = r_fb_valid;
    w_fb_tag_next   = r_fb_tag;
    w_fb_data_next  = r_fb_data;
    if (w_rd_done && (r_last_grant == GRANT_IF)) begin
      w_fb_valid_next = 1'b1;
      w_fb_tag_next   = r_ram_addr;
      w_fb_data_next  = ram_rdata;
    end
    if (w_wr_done) begin
      w_fb_valid_next = 1'b0;
    end
  end

  // Fetch buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fb_valid <= 1'b0;
      r_fb_tag   <= '0;
      r_fb_data  <= '0;
    end else begin
      r_fb_valid <= w_fb_valid_next;
      r_fb_tag   <= w_fb_tag_next;
      r_fb_data  <= w_fb_data_next;
    end
  end
`else
  assign w_fb_hit  = 1'b0;
  assign w_fb_data = 16'h0000;
`endif

  // Next state and next registered pin values; pins track the state they enter
  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_cnt_next        = r_cnt;
    w_if_ack_next     = 1'b0;
    w_mem_ack_next    = 1'b0;
    w_if_rdata_next   = r_if_rdata;
    w_mem_rdata_next  = r_mem_rdata;
    w_ram_addr_next   = r_ram_addr;
    w_ram_wdata_next  = r_ram_wdata;
    w_data_oe_next    = r_data_oe;
    w_ce_n_next       = r_ce_n;
    w_oe_n_next       = r_oe_n;
    w_we_n_next       = r_we_n;

    unique case (r_state)
      S_IDLE: begin
        if (w_fb_hit) begin
          w_if_ack_next   = 1'b1;
          w_if_rdata_next = w_fb_data;
          w_state_next    = S_ACK;
        end else if (if_req | mem_req) begin
          w_last_grant_next = w_pick_mem ? GRANT_MEM : GRANT_IF;
          w_ram_addr_next   = w_pick_mem ? mem_addr : if_addr;
          w_ce_n_next       = 1'b0;
          w_cnt_next        = 3'd0;
          if (w_pick_mem && mem_we) begin
            w_ram_wdata_next = mem_wdata;
            w_data_oe_next   = 1'b1;
            w_state_next     = S_WR_SETUP;
          end else begin
            w_oe_n_next  = 1'b0;
            w_state_next = S_RD_STB;
          end
        end
      end

      S_RD_STB: begin
        if (w_stb_last) begin
          if (r_last_grant == GRANT_MEM) begin
            w_mem_rdata_next = ram_rdata;
            w_mem_ack_next   = 1'b1;
          end else begin
            w_if_rdata_next = ram_rdata;
            w_if_ack_next   = 1'b1;
          end
          w_oe_n_next  = 1'b1;
          w_ce_n_next  = 1'b1;
          w_state_next = S_ACK;
        end else begin
          w_cnt_next = r_cnt + 3'd1;
        end
      end

      S_WR_SETUP: begin
        w_we_n_next  = 1'b0;
        w_cnt_next   = 3'd0;
        w_state_next = S_WR_STB;
      end

      S_WR_STB: begin
        if (w_stb_last) begin
          // data stays driven through the ack cycle as hold time
          w_we_n_next    = 1'b1;
          w_ce_n_next    = 1'b1;
          w_mem_ack_next = 1'b1;
          w_state_next   = S_ACK;
        end else begin
          w_cnt_next = r_cnt + 3'd1;
        end
      end

      S_ACK: begin
        w_data_oe_next = 1'b0;
        w_state_next   = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset idles every SRAM control at once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_IF;
      r_cnt        <= 3'd0;
      r_if_ack     <= 1'b0;
      r_mem_ack    <= 1'b0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_data_oe    <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_cnt        <= w_cnt_next;
      r_if_ack     <= w_if_ack_next;
      r_mem_ack    <= w_mem_ack_next;
      r_if_rdata   <= w_if_rdata_next;
      r_mem_rdata  <= w_mem_rdata_next;
      r_ram_addr   <= w_ram_addr_next;
      r_ram_wdata  <= w_ram_wdata_next;
      r_data_oe    <= w_data_oe_next;
      r_ce_n       <= w_ce_n_next;
      r_oe_n       <= w_oe_n_next;
      r_we_n       <= w_we_n_next;
    end
  end

endmodule
